// File: rtl/mem_io_pkg.sv
// Shared address map and access classification for the CPU memory responder.
package mem_io_pkg;

   localparam logic [1:0]  IO_SEL       = 2'b11;
   localparam logic [17:0] IO_UART_ADDR = 18'h30000;
   localparam logic [17:0] IO_CLK_ADDR  = 18'h30004;

   typedef enum logic [1:0] {ACC_RAM, ACC_UART, ACC_CLK, ACC_NONE} acc_t;

   function automatic acc_t decode_acc(input logic [17:0] a);
      acc_t r;
      if (a[17:16] != IO_SEL)
         r = ACC_RAM;
      else if (a == IO_UART_ADDR)
         r = ACC_UART;
      else if (a[17:2] == IO_CLK_ADDR[17:2])
         r = ACC_CLK;
      else
         r = ACC_NONE;
      return r;
   endfunction

endpackage

// File: rtl/resp_tx_fifo.sv
// Byte FIFO feeding the UART transmitter; near_full is registered from the post-update count.
module resp_tx_fifo
   import mem_io_pkg::*;
#(
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk_in,
   input  logic                     rst_in,
   input  logic                     push,
   input  logic [7:0]               push_data,
   input  logic                     pop,
   output logic [7:0]               head_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     near_full
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] NEAR_C  = CW'(DEPTH - 2);

   logic [7:0]    mem [0:DEPTH-1];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count_nxt;
   logic          pop_ok;
   logic          push_ok;

   assign empty     = (count == '0);
   assign head_data = empty ? '0 : mem[rd_ptr];
   assign pop_ok    = pop && !empty;
   // A pop in the same cycle frees the slot, so a push at full still lands.
   assign push_ok   = push && ((count < DEPTH_C) || pop_ok);

   always_comb begin
      count_nxt = count;
      if (push_ok && !pop_ok)
         count_nxt = count + 1'b1;
      else if (!push_ok && pop_ok)
         count_nxt = count - 1'b1;
   end

   always_ff @(posedge clk_in) begin
      if (push_ok)
         mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         near_full <= 1'b0;
      end else begin
         if (push_ok)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)
            rd_ptr <= rd_ptr + 1'b1;
         count     <= count_nxt;
         near_full <= (count_nxt >= NEAR_C);
      end
   end

endmodule

// File: rtl/mem_io_responder.sv
// CPU byte-bus responder: 128 KB RAM plus UART / cycle-counter / stop I/O window at 0x30000.
// Define MEM_IO_CLK_COUNTER_EN to build the cycle counter and its 0x30004-0x30007 readback.
module mem_io_responder
   import mem_io_pkg::*;
#(
   parameter int unsigned RAM_ADDR_W    = 17,
   parameter int unsigned TX_FIFO_DEPTH = 8
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [31:0] mem_a,
   input  logic        mem_wr,
   input  logic [7:0]  mem_dout,
   output logic [7:0]  mem_din,
   output logic        io_buffer_full,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic        program_finish
);

   logic [7:0]                ram [0:(1 << RAM_ADDR_W) - 1];
   logic [17:0]               a18;
   logic [RAM_ADDR_W-1:0]     ram_a;
   acc_t                      acc;
   logic                      uart_rd;
   logic                      prev_uart_rd;
   logic                      io_wr_en;
   logic                      fin_wr;
   logic                      push;
   logic [7:0]                push_data;
   logic [7:0]                rd_data;
   logic                      fifo_empty;
   logic [$clog2(TX_FIFO_DEPTH):0] unused_tx_count;
   logic                      unused_hi;

   assign a18       = mem_a[17:0];
   assign ram_a     = mem_a[RAM_ADDR_W-1:0];
   assign acc       = decode_acc(a18);
   assign unused_hi = ^mem_a[31:18];

   assign uart_rd   = !mem_wr && (acc == ACC_UART);
   // Held read address pops the RX stream only on its first cycle.
   assign rx_ready  = uart_rd && rx_valid && !prev_uart_rd;

   assign io_wr_en  = mem_wr && !program_finish;
   assign fin_wr    = io_wr_en && (a18 == IO_CLK_ADDR);
   assign push      = fin_wr || (io_wr_en && (acc == ACC_UART) && (mem_dout != '0));
   assign push_data = fin_wr ? '0 : mem_dout;

`ifdef MEM_IO_CLK_COUNTER_EN
   logic [31:0] cycle_cnt;
   logic [31:0] clk_snap;
   logic        unused_snap;

   assign unused_snap = ^clk_snap[7:0];

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         cycle_cnt <= '0;
         clk_snap  <= '0;
      end else begin
         cycle_cnt <= cycle_cnt + 32'd1;
         if (!mem_wr && (a18 == IO_CLK_ADDR))
            clk_snap <= cycle_cnt;
      end
   end
`endif

   always_comb begin
      rd_data = '0;
      case (acc)
         ACC_RAM:  rd_data = ram[ram_a];
         ACC_UART: if (rx_valid) rd_data = rx_data;
`ifdef MEM_IO_CLK_COUNTER_EN
         // Byte 0 comes live from the counter; bytes 1-3 from the snapshot taken with it.
         ACC_CLK: begin
            case (a18[1:0])
               2'd0:    rd_data = cycle_cnt[7:0];
               2'd1:    rd_data = clk_snap[15:8];
               2'd2:    rd_data = clk_snap[23:16];
               default: rd_data = clk_snap[31:24];
            endcase
         end
`endif
         default:  rd_data = '0;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (mem_wr && (acc == ACC_RAM))
         ram[ram_a] <= mem_dout;
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         mem_din        <= '0;
         prev_uart_rd   <= 1'b0;
         program_finish <= 1'b0;
      end else begin
         if (!mem_wr)
            mem_din <= rd_data;
         prev_uart_rd <= uart_rd;
         if (fin_wr)
            program_finish <= 1'b1;
      end
   end

   resp_tx_fifo #(
      .DEPTH (TX_FIFO_DEPTH)
   ) u_tx_fifo (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .push      (push),
      .push_data (push_data),
      .pop       (tx_ready),
      .head_data (tx_data),
      .count     (unused_tx_count),
      .empty     (fifo_empty),
      .near_full (io_buffer_full)
   );

   assign tx_valid = !fifo_empty;

endmodule

// File: tb/tb_mem_io_responder.sv
// Self-checking bench for mem_io_responder: directed table, corner sequences, randomized traffic vs model.
module tb_mem_io_responder;

   localparam int DEPTH = 8;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic [31:0] mem_a;
   logic        mem_wr;
   logic [7:0]  mem_dout;
   logic [7:0]  mem_din;
   logic        io_buffer_full;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        program_finish;

   mem_io_responder #(
      .RAM_ADDR_W    (17),
      .TX_FIFO_DEPTH (DEPTH)
   ) dut (
      .clk_in         (clk_in),
      .rst_in         (rst_in),
      .mem_a          (mem_a),
      .mem_wr         (mem_wr),
      .mem_dout       (mem_dout),
      .mem_din        (mem_din),
      .io_buffer_full (io_buffer_full),
      .tx_data        (tx_data),
      .tx_valid       (tx_valid),
      .tx_ready       (tx_ready),
      .rx_data        (rx_data),
      .rx_valid       (rx_valid),
      .rx_ready       (rx_ready),
      .program_finish (program_finish)
   );

   always #5 clk_in = ~clk_in;

   int passed = 0;
   int total  = 0;

   // Reference model state
   byte unsigned ram_m [int];
   byte unsigned txq [$];
   bit           fin_m;
   bit           prev_m;
   bit           din_known;
   logic [7:0]   din_m;
   int unsigned  cnt_m;
   int unsigned  snap_m;
   logic         rxr_seen;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   task automatic check_outputs();
      if (din_known) chk("mem_din", 32'(mem_din), 32'(din_m));
      chk("tx_valid", 32'(tx_valid), 32'(txq.size() > 0));
      chk("tx_data", 32'(tx_data), (txq.size() > 0) ? 32'(txq[0]) : 32'd0);
      chk("io_buffer_full", 32'(io_buffer_full), 32'(txq.size() >= DEPTH - 2));
      chk("program_finish", 32'(program_finish), 32'(fin_m));
   endtask

   task automatic do_reset();
      rst_in = 1'b1; mem_wr = 1'b0; mem_a = 32'h0003000C; mem_dout = '0;
      tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
      @(posedge clk_in); #1;
      rst_in = 1'b0;
      txq.delete();
      fin_m = 0; prev_m = 0; cnt_m = 0; snap_m = 0; din_m = '0; din_known = 1;
      chk("rst_mem_din", 32'(mem_din), 32'd0);
      chk("rst_tx_valid", 32'(tx_valid), 32'd0);
      chk("rst_tx_data", 32'(tx_data), 32'd0);
      chk("rst_io_buffer_full", 32'(io_buffer_full), 32'd0);
      chk("rst_program_finish", 32'(program_finish), 32'd0);
   endtask

   // One bus cycle: drive, check the combinational pop strobe, advance the model, check after the edge.
   task automatic cyc(input bit wr, input logic [31:0] a, input logic [7:0] d,
                      input bit txr, input bit rxv, input logic [7:0] rxd);
      logic [17:0] a18;
      bit          is_io;
      bit          rd_uart;
      int unsigned sel;
      a18 = a[17:0];
      is_io = (a18[17:16] == 2'b11);
      mem_wr = wr; mem_a = a; mem_dout = d; tx_ready = txr; rx_valid = rxv; rx_data = rxd;
      #1;
      rd_uart = !wr && (a18 == 18'h30000);
      rxr_seen = rx_ready;
      chk("rx_ready", 32'(rx_ready), 32'(rd_uart && rxv && !prev_m));

      if (txr && txq.size() > 0) void'(txq.pop_front());
      if (wr && is_io && !fin_m) begin
         if (a18 == 18'h30000 && d != 8'h00) begin
            if (txq.size() < DEPTH) txq.push_back(d);
         end else if (a18 == 18'h30004) begin
            if (txq.size() < DEPTH) txq.push_back(8'h00);
            fin_m = 1;
         end
      end
      if (!wr) begin
         din_known = 1;
         if (!is_io) begin
            if (ram_m.exists(int'(a[16:0]))) din_m = ram_m[int'(a[16:0])];
            else din_known = 0;
         end else if (a18 == 18'h30000) begin
            din_m = rxv ? rxd : 8'h00;
         end else if (a18 >= 18'h30004 && a18 <= 18'h30007) begin
            sel = int'(a18) - 'h30004;
`ifdef MEM_IO_CLK_COUNTER_EN
            if (sel == 0) begin
               din_m  = 8'(cnt_m);
               snap_m = cnt_m;
            end else begin
               din_m = 8'(snap_m >> (8 * sel));
            end
`else
            din_m = 8'h00;
`endif
         end else begin
            din_m = 8'h00;
         end
      end else if (!is_io) begin
         ram_m[int'(a[16:0])] = d;
      end
      prev_m = rd_uart;

      @(posedge clk_in); #1;
      cnt_m++;
      check_outputs();
   endtask

   typedef struct {
      bit          wr;
      logic [31:0] a;
      logic [7:0]  d;
      bit          txr;
      bit          rxv;
      logic [7:0]  rxd;
      logic [7:0]  e_din;
      bit          e_txv;
      logic [7:0]  e_txd;
      bit          e_rxr;
   } vec_t;

   vec_t tbl [11];

   initial begin
      logic [31:0] dword;
      logic [31:0] addr;
      logic [31:0] low;
      bit          wr;
      logic [7:0]  exp_b;

      tbl[0]  = '{1'b1, 32'h00001234, 8'hA5, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
      tbl[1]  = '{1'b0, 32'h00001234, 8'h00, 1'b1, 1'b0, 8'h00, 8'hA5, 1'b0, 8'h00, 1'b0};
      tbl[2]  = '{1'b1, 32'h00030000, 8'h48, 1'b1, 1'b0, 8'h00, 8'hA5, 1'b1, 8'h48, 1'b0};
      tbl[3]  = '{1'b1, 32'h00030000, 8'h00, 1'b1, 1'b0, 8'h00, 8'hA5, 1'b0, 8'h00, 1'b0};
      tbl[4]  = '{1'b1, 32'h00030000, 8'h69, 1'b1, 1'b0, 8'h00, 8'hA5, 1'b1, 8'h69, 1'b0};
      tbl[5]  = '{1'b0, 32'h0003000C, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
      tbl[6]  = '{1'b0, 32'h00030000, 8'h00, 1'b1, 1'b1, 8'h37, 8'h37, 1'b0, 8'h00, 1'b1};
      tbl[7]  = '{1'b0, 32'h00030000, 8'h00, 1'b1, 1'b1, 8'h37, 8'h37, 1'b0, 8'h00, 1'b0};
      tbl[8]  = '{1'b0, 32'h00030000, 8'h00, 1'b1, 1'b1, 8'h37, 8'h37, 1'b0, 8'h00, 1'b0};
      tbl[9]  = '{1'b0, 32'h00030000, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
      tbl[10] = '{1'b0, 32'hDEAC1234, 8'h00, 1'b1, 1'b1, 8'h55, 8'hA5, 1'b0, 8'h00, 1'b0};

      do_reset();

      for (int i = 0; i < 11; i++) begin
         cyc(tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].txr, tbl[i].rxv, tbl[i].rxd);
         chk($sformatf("tbl%0d_rx_ready", i), 32'(rxr_seen), 32'(tbl[i].e_rxr));
         chk($sformatf("tbl%0d_mem_din", i), 32'(mem_din), 32'(tbl[i].e_din));
         chk($sformatf("tbl%0d_tx_valid", i), 32'(tx_valid), 32'(tbl[i].e_txv));
         chk($sformatf("tbl%0d_tx_data", i), 32'(tx_data), 32'(tbl[i].e_txd));
      end

      // Fill with the transmitter stalled; ninth push is dropped.
      for (int i = 0; i < 9; i++) begin
         cyc(1'b1, 32'h00030000, 8'h41 + 8'(i), 1'b0, 1'b0, 8'h00);
         chk($sformatf("fill%0d_full", i), 32'(io_buffer_full), (i >= 5) ? 32'd1 : 32'd0);
      end
      // Push and pop together at full: count unchanged, new byte goes to the tail.
      cyc(1'b1, 32'h00030000, 8'h50, 1'b1, 1'b0, 8'h00);
      chk("full_pushpop_head", 32'(tx_data), 32'h42);
      chk("full_pushpop_full", 32'(io_buffer_full), 32'd1);
      for (int k = 0; k < 8; k++) begin
         exp_b = (k < 7) ? 8'h42 + 8'(k) : 8'h50;
         chk($sformatf("drain%0d", k), 32'(tx_data), 32'(exp_b));
         cyc(1'b0, 32'h0003000C, 8'h00, 1'b1, 1'b0, 8'h00);
      end
      chk("drain_empty", 32'(tx_valid), 32'd0);

      // Stop write, then I/O writes are ignored but RAM stays writable.
      cyc(1'b1, 32'h00030004, 8'hFF, 1'b1, 1'b0, 8'h00);
      chk("stop_tx_valid", 32'(tx_valid), 32'd1);
      chk("stop_tx_data", 32'(tx_data), 32'h00);
      chk("stop_finish", 32'(program_finish), 32'd1);
      cyc(1'b0, 32'h0003000C, 8'h00, 1'b1, 1'b0, 8'h00);
      chk("stop_drained", 32'(tx_valid), 32'd0);
      cyc(1'b1, 32'h00030000, 8'h41, 1'b1, 1'b0, 8'h00);
      chk("post_stop_no_push", 32'(tx_valid), 32'd0);
      cyc(1'b1, 32'h00000055, 8'h3C, 1'b1, 1'b0, 8'h00);
      cyc(1'b0, 32'h00000055, 8'h00, 1'b1, 1'b0, 8'h00);
      chk("post_stop_ram", 32'(mem_din), 32'h3C);
      chk("finish_held", 32'(program_finish), 32'd1);
      do_reset();

      // Cycle counter dword read 1000 cycles after reset.
      while (cnt_m < 1000) cyc(1'b0, 32'h0003000C, 8'h00, 1'b0, 1'b0, 8'h00);
      dword = '0;
      for (int k = 0; k < 4; k++) begin
         cyc(1'b0, 32'h00030004 + 32'(k), 8'h00, 1'b0, 1'b0, 8'h00);
         dword = dword | (32'(mem_din) << (8 * k));
      end
`ifdef MEM_IO_CLK_COUNTER_EN
      chk("clk_dword", dword, 32'd1000);
`else
      chk("clk_dword", dword, 32'd0);
`endif

      // Randomized traffic against the model.
      do_reset();
      for (int k = 0; k < 8; k++)
         cyc(1'b1, 32'h00000010 + 32'(k), 8'($urandom), 1'b1, 1'b0, 8'h00);
      cyc(1'b1, 32'h0000ABCD, 8'h11, 1'b1, 1'b0, 8'h00);
      cyc(1'b1, 32'h0001FFFF, 8'h22, 1'b1, 1'b0, 8'h00);
      cyc(1'b1, 32'h0000FFF0, 8'h33, 1'b1, 1'b0, 8'h00);
      addr = 32'h00030000;
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 399) == 0) do_reset();
         if ($urandom_range(0, 9) >= 3) begin
            case ($urandom_range(0, 13))
               0, 1:    low = 32'h00010 + 32'($urandom_range(0, 7));
               2:       low = 32'h0ABCD;
               3:       low = 32'h1FFFF;
               4:       low = 32'h2FFF0;
               5:       low = 32'h0FFF0;
               6, 7, 8: low = 32'h30000;
               9:       low = 32'h30004;
               10:      low = 32'h30005 + 32'($urandom_range(0, 2));
               11:      low = 32'h30008;
               12:      low = 32'h3FFFF;
               default: low = 32'h30000;
            endcase
            addr = ($urandom() & 32'hFFFC0000) | low;
         end
         wr = ($urandom_range(0, 1) == 1);
         if (wr && addr[17:0] == 18'h30004 && $urandom_range(0, 39) != 0) wr = 1'b0;
         cyc(wr, addr, 8'($urandom_range(0, 3) == 0 ? 0 : $urandom), ($urandom_range(0, 9) < 7),
             ($urandom_range(0, 1) == 1), 8'($urandom));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
